// File: rtl/seg_scan_if.sv
// Bus between the seg_scan multiplexer and its host/driver side: BCD load
// strobe, display enable, and the 16-bit word stream to the 74HC595 driver.
interface seg_scan_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] bcd_data;
    logic                bcd_vld;
    logic [DIGITS-1:0]   dp_mask;
    logic                disp_en;
    logic [15:0]         dout;
    logic                dout_vld;
    logic [2:0]          digit_idx;

    modport master (
        output bcd_data, bcd_vld, dp_mask, disp_en,
        input  dout, dout_vld, digit_idx
    );

    modport slave (
        input  bcd_data, bcd_vld, dp_mask, disp_en,
        output dout, dout_vld, digit_idx
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner producing {seg, sel} words for a 74HC595 driver.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros (digit 0 always shown).
module seg_scan #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, HOLD, BLANK} state_t;

    localparam int             CNT_W      = $clog2(SCAN_DIV + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SCAN_DIV - 3);
    localparam logic [CNT_W-1:0] BLANK_VLD  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(SCAN_DIV);
    localparam logic [2:0]     IDX_LAST   = 3'(DIGITS - 1);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [2:0]              idx, idx_next;
    logic                    stop_req, stop_next;
    logic                    vld;
    logic [15:0]             dout_r;
    logic [15:0]             word_load;
    logic [DIGITS-1:0][3:0]  shadow_bcd;
    logic [DIGITS-1:0]       shadow_dp;
    logic [DIGITS-1:0]       lz;

    function automatic logic [7:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 8'hC0;
            4'd1:    seg_lut = 8'hF9;
            4'd2:    seg_lut = 8'hA4;
            4'd3:    seg_lut = 8'hB0;
            4'd4:    seg_lut = 8'h99;
            4'd5:    seg_lut = 8'h92;
            4'd6:    seg_lut = 8'h82;
            4'd7:    seg_lut = 8'hF8;
            4'd8:    seg_lut = 8'h80;
            4'd9:    seg_lut = 8'h90;
            default: seg_lut = 8'hFF;
        endcase
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    // Zero run from the top digit down; digit 0 is never part of the run.
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run   = run & (shadow_bcd[k] == 4'd0);
            lz[k] = run;
        end
    end
`else
    assign lz = '0;
`endif

    // Word for the digit about to be loaded; indexed by idx_next so dout is
    // already valid during the LOAD cycle.
    always_comb begin
        logic [3:0] digit;
        logic       dp_on;
        logic       blank;
        logic [7:0] seg;
        logic [7:0] sel;
        digit = 4'hF;
        dp_on = 1'b0;
        blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_next == 3'(k)) begin
                digit = shadow_bcd[k];
                dp_on = shadow_dp[k];
                blank = lz[k];
            end
        end
        seg = blank ? 8'hFF : seg_lut(digit);
        if (dp_on) seg[7] = 1'b0;
        sel       = 8'hFF ^ (8'h01 << idx_next);
        word_load = {seg, sel};
    end

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        stop_next  = stop_req;
        vld        = 1'b0;
        case (state)
            IDLE: begin
                stop_next = 1'b0;
                idx_next  = '0;
                cnt_next  = '0;
                if (bus.disp_en) state_next = LOAD;
            end
            LOAD: begin
                if (!bus.disp_en) stop_next = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                vld      = 1'b1;
                cnt_next = '0;
                if (!bus.disp_en) stop_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!bus.disp_en) stop_next = 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_next = '0;
                    if (stop_req || !bus.disp_en) begin
                        state_next = BLANK;
                        idx_next   = '0;
                    end else begin
                        state_next = LOAD;
                        idx_next   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BLANK: begin
                // Cycle 0 mirrors LOAD, cycle 1 mirrors SEND, then SCAN_DIV-1 wait.
                stop_next = 1'b0;
                vld       = (cnt == BLANK_VLD);
                if (cnt == BLANK_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the shadow
    // register is reset too so the first word after reset is deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            stop_req   <= 1'b0;
            dout_r     <= 16'hFFFF;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            stop_req <= stop_next;
            if (bus.bcd_vld) begin
                shadow_bcd <= bus.bcd_data;
                shadow_dp  <= bus.dp_mask;
            end
            if (state_next == LOAD)
                dout_r <= word_load;
            else if (state_next == BLANK && state != BLANK)
                dout_r <= 16'hFFFF;
        end
    end

    assign bus.dout      = dout_r;
    assign bus.dout_vld  = vld;
    assign bus.digit_idx = idx;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=6, SCAN_DIV=200): expected words with
// their exact issue cycle are queued as stimulus is applied and popped on dout_vld.
module tb_seg_scan;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 200;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  idx;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   vld_count = 0;
    exp_t sb[$];
    exp_t e;

    seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [23:0] bcd, input logic [5:0] dp, input int k);
        logic [7:0] seg;
        logic [3:0] d;
        bit         lead;
        d = bcd[4*k +: 4];
        case (d)
            4'd0: seg = 8'hC0;  4'd1: seg = 8'hF9;  4'd2: seg = 8'hA4;
            4'd3: seg = 8'hB0;  4'd4: seg = 8'h99;  4'd5: seg = 8'h92;
            4'd6: seg = 8'h82;  4'd7: seg = 8'hF8;  4'd8: seg = 8'h80;
            4'd9: seg = 8'h90;  default: seg = 8'hFF;
        endcase
`ifdef LEAD_ZERO_BLANK_EN
        lead = (k != 0);
        for (int j = k; j < DIGITS; j++)
            if (bcd[4*j +: 4] != 4'd0) lead = 1'b0;
        if (lead) seg = 8'hFF;
`else
        lead = 1'b0;
        if (lead) seg = 8'hFF;
`endif
        if (dp[k]) seg[7] = 1'b0;
        return {seg, 8'hFF & ~(8'h01 << k)};
    endfunction

    task automatic push(input logic [23:0] bcd, input logic [5:0] dp, input int k, input int at);
        exp_t x;
        x.word = model_word(bcd, dp, k);
        x.idx  = 3'(k);
        x.at   = at;
        sb.push_back(x);
    endtask

    task automatic push_blank(input int at);
        exp_t x;
        x.word = 16'hFFFF;
        x.idx  = 3'd0;
        x.at   = at;
        sb.push_back(x);
    endtask

    task automatic load(input logic [23:0] d, input logic [5:0] m);
        bus.bcd_data = d;
        bus.dp_mask  = m;
        bus.bcd_vld  = 1'b1;
        @(negedge clk);
        bus.bcd_vld  = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: every dout_vld must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (bus.dout_vld) begin
            vld_count++;
            if (sb.size() == 0) begin
                check("unexpected_vld", bus.dout, 32'hDEAD_0000);
            end else begin
                e = sb.pop_front();
                check("word", bus.dout, e.word);
                check("idx", bus.digit_idx, e.idx);
                check("vld_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r, c0;
        rst          = 1'b1;
        bus.bcd_data = '0;
        bus.bcd_vld  = 1'b0;
        bus.dp_mask  = '0;
        bus.disp_en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.dout, 16'hFFFF);
        check("rst_vld", bus.dout_vld, 0);
        check("rst_idx", bus.digit_idx, 0);
        rst = 1'b0;

        // Full scan with wrap; SEND is the third cycle counting the one where disp_en is first seen.
        load(24'h123456, 6'b000100);
        repeat (3) @(negedge clk);
        t = cyc + 2;
        for (int k = 0; k < 8; k++) push(24'h123456, 6'b000100, k % DIGITS, t + SCAN_DIV * k);
        bus.disp_en = 1'b1;

        // New data strobed while digit 1 (second pass) is in LOAD: only digit 2 onward sees it.
        wait_cyc(t + 7 * SCAN_DIV - 1);
        load(24'h987604, 6'b100001);
        push(24'h987604, 6'b100001, 2, t + 8 * SCAN_DIV);
        push_blank(t + 9 * SCAN_DIV);

        // Drop enable mid-HOLD of digit 2: slot finishes, one blank word, then silence.
        wait_cyc(t + 8 * SCAN_DIV + 50);
        bus.disp_en = 1'b0;
        drain(3 * SCAN_DIV);
        c0 = vld_count;
        repeat (2 * SCAN_DIV + 50) @(negedge clk);
        check("idle_no_vld", vld_count, c0);
        check("idle_dout", bus.dout, 16'hFFFF);
        check("idle_idx", bus.digit_idx, 0);

        // Invalid BCD and leading zeros.
        load(24'h00000A, 6'b000000);
        repeat (3) @(negedge clk);
        t = cyc + 2;
        for (int k = 0; k < DIGITS; k++) push(24'h00000A, 6'b000000, k, t + SCAN_DIV * k);
        bus.disp_en = 1'b1;

        // One-cycle reset at cycle 90 of digit 5's HOLD.
        wait_cyc(t + 5 * SCAN_DIV + 89);
        check("q_before_rst", sb.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        r = cyc;
        check("midrst_dout", bus.dout, 16'hFFFF);
        check("midrst_vld", bus.dout_vld, 0);
        check("midrst_idx", bus.digit_idx, 0);
        rst = 1'b0;
        // Shadow was cleared by reset, so digit 0 shows 0.
        push(24'h000000, 6'b000000, 0, r + 2);
        push_blank(r + 2 + SCAN_DIV);

        // Re-enable during BLANK: blank slot completes, IDLE, LOAD, SEND.
        wait_cyc(r + 100);
        bus.disp_en = 1'b0;
        wait_cyc(r + 300);
        bus.disp_en = 1'b1;
        push(24'h000000, 6'b000000, 0, r + 404);
        wait_cyc(r + 450);
        bus.disp_en = 1'b0;
        push_blank(r + 404 + SCAN_DIV);
        drain(4 * SCAN_DIV);
        repeat (SCAN_DIV + 20) @(negedge clk);
        check("final_no_extra", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
